// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the round-robin fifo drain block.
package fifo_drain_pkg;

  localparam int DRAIN_DATA_W = 16;
  localparam int DRAIN_CH_W   = 2;
  localparam int BUF_DEPTH    = 2;

  typedef logic [DRAIN_CH_W-1:0] ch_idx_t;

  typedef struct packed {
    logic [DRAIN_DATA_W-1:0] data;
    ch_idx_t                 ch;
  } buf_entry_t;

  // Next round-robin position after idx, wrapping num-1 -> 0.
  function automatic int rr_next(input int idx, input int num);
    return (idx >= num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_drain_buf.sv
// Two-entry FIFO-ordered output buffer presenting a valid/ready read side.
module fifo_drain_buf
  import fifo_drain_pkg::*;
#(
  parameter type entry_t = buf_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  entry_t wr_entry,
  output logic   rd_valid,
  input  logic   rd_ready,
  output entry_t rd_entry,
  output logic [1:0] occ
);

  entry_t     entry_reg [BUF_DEPTH];
  logic       head_reg;
  logic [1:0] occ_reg;
  logic       tail_idx;
  logic       deq;

  assign deq      = rd_valid & rd_ready;
  // The issue rule keeps a write from ever meeting a full buffer, so the tail
  // is the slot after the head whenever one word is already held.
  assign tail_idx = head_reg ^ occ_reg[0];

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg[gi] <= '0;
      end else if (wr_en && (tail_idx == 1'(gi))) begin
        entry_reg[gi] <= wr_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= 1'b0;
      occ_reg  <= 2'd0;
    end else begin
      if (deq) begin
        head_reg <= ~head_reg;
      end
      occ_reg <= occ_reg + {1'b0, wr_en} - {1'b0, deq};
    end
  end

  assign rd_valid = (occ_reg != 2'd0);
  assign rd_entry = entry_reg[head_reg];
  assign occ      = occ_reg;

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH registered-read fifos into one tagged valid/ready stream.
// Optional accepted-word counter on o_cnt when FIFO_DRAIN_STATS_EN is defined.
module fifo_rr_drain
  import fifo_drain_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_empty,
  output logic [NUM_CH-1:0]        ch_pop,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_ch,
  output logic [CNT_W-1:0]         o_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
  } entry_t;

  logic [DATA_W-1:0] ch_word [NUM_CH];
  logic [CH_W-1:0]   rr_ptr_reg;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   inflight_ch_reg;
  logic              inflight_reg;
  logic              grant_found;
  logic              pop_allowed;
  logic              issue;
  logic              deq;
  logic [1:0]        occ;
  logic [2:0]        load;
  entry_t            wr_entry;
  entry_t            rd_entry;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_word[gi] = ch_data[gi*DATA_W +: DATA_W];
    assign ch_pop[gi]  = issue && (grant_idx == CH_W'(gi));
  end

  // Scan from the far end toward rr_ptr so the closest non-empty channel wins.
  always_comb begin
    int            cand;
    logic [CH_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = rr_ptr_reg;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_idx = CH_W'(cand);
      if (!ch_empty[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // A word already in flight still needs a buffer slot, so it counts as held.
  assign deq         = o_valid & o_ready;
  assign load        = {1'b0, occ} + {2'b00, inflight_reg};
  assign pop_allowed = (load - {2'b00, deq}) < 3'd2;
  assign issue       = grant_found & pop_allowed & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg      <= '0;
      inflight_reg    <= 1'b0;
      inflight_ch_reg <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        rr_ptr_reg      <= CH_W'(rr_next(int'(grant_idx), NUM_CH));
        inflight_ch_reg <= grant_idx;
      end
    end
  end

  assign wr_entry = '{data: ch_word[inflight_ch_reg], ch: inflight_ch_reg};

  fifo_drain_buf #(
    .entry_t(entry_t)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (inflight_reg),
    .wr_entry (wr_entry),
    .rd_valid (o_valid),
    .rd_ready (o_ready),
    .rd_entry (rd_entry),
    .occ      (occ)
  );

  assign o_data = rd_entry.data;
  assign o_ch   = rd_entry.ch;

`ifdef FIFO_DRAIN_STATS_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (deq) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_cnt = cnt_reg;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain with a registered-read fifo model per channel.
module tb_fifo_rr_drain;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 32;
  localparam int MEMD   = 16;
`ifdef FIFO_DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_empty;
  logic [NUM_CH-1:0]        ch_pop;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     o_valid;
  logic                     o_ready = 1'b0;
  logic [DATA_W-1:0]        o_data;
  logic [CH_W-1:0]          o_ch;
  logic [CNT_W-1:0]         o_cnt;

  always #5 clk = ~clk;

  fifo_rr_drain #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_empty (ch_empty),
    .ch_pop   (ch_pop),
    .ch_data  (ch_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_ch     (o_ch),
    .o_cnt    (o_cnt)
  );

  // Upstream fifo model: word appears on ch_data the cycle after its pop.
  logic [DATA_W-1:0] mem [NUM_CH][MEMD];
  int                wr_cnt [NUM_CH];
  int                rd_idx [NUM_CH];
  logic [DATA_W-1:0] fifo_q [NUM_CH];

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      wr_cnt[k] = 0;
      rd_idx[k] = 0;
      fifo_q[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_pop[k] && (rd_idx[k] != wr_cnt[k])) begin
        fifo_q[k] <= mem[k][rd_idx[k] % MEMD];
        rd_idx[k] <= rd_idx[k] + 1;
      end
    end
  end

  always_comb begin
    ch_empty = '0;
    ch_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_empty[k]                 = (rd_idx[k] == wr_cnt[k]);
      ch_data[k*DATA_W +: DATA_W] = fifo_q[k];
    end
  end

  // Monitor: logs accepted words and pops, sampled mid-cycle.
  int                cyc = 0;
  logic [DATA_W-1:0] acc_data [$];
  logic [CH_W-1:0]   acc_ch [$];
  int                acc_cyc [$];
  int                pop_ch [$];
  int                pop_cyc [$];
  int                acc_since_rst = 0;
  int                proto_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      acc_since_rst = 0;
    end else begin
      if (o_valid && o_ready) begin
        acc_data.push_back(o_data);
        acc_ch.push_back(o_ch);
        acc_cyc.push_back(cyc);
        acc_since_rst++;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_pop[k]) begin
          pop_ch.push_back(k);
          pop_cyc.push_back(cyc);
        end
      end
      if (!$onehot0(ch_pop) || ((ch_pop & ch_empty) != '0)) proto_err++;
    end
  end

  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } vec_t;

  vec_t exp_tab [12];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [DATA_W-1:0] w);
    mem[k][wr_cnt[k] % MEMD] = w;
    wr_cnt[k] = wr_cnt[k] + 1;
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (acc_data.size() < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_count"}, acc_data.size(), target);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(o_valid == 1'b0 && ch_empty == '1) && n < 60) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, "_idle"}, {o_valid, ch_empty}, {1'b0, 4'hf});
  endtask

  task automatic check_seq(input string name, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ch%0d", name, i), acc_ch[base+i], exp_tab[i].ch);
      check($sformatf("%s_data%0d", name, i), acc_data[base+i], exp_tab[i].data);
    end
  endtask

  initial begin
    int               ab;
    int               pb;
    int               changes;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] exp_first;
    logic [CNT_W-1:0]  cnt_base;

    // Reset state; a non-empty channel during reset must not be popped.
    repeat (2) tick();
    push(3, 16'h3fff);
    #1;
    check("rst_pop", ch_pop, 4'h0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 16'h0000);
    check("rst_ch", o_ch, 2'd0);
    check("rst_cnt", o_cnt, 32'd0);
    tick();
    rst = 1'b0;
    o_ready = 1'b1;
    wait_acc("warm", 1, 20);
    check("warm_data", acc_data[0], 16'h3fff);
    check("warm_ch", acc_ch[0], 2'd3);
    wait_idle("warm");

    // All channels, three words each, round-robin from channel 0.
    exp_tab = '{'{0,16'h0000}, '{1,16'h1000}, '{2,16'h2000}, '{3,16'h3000},
                '{0,16'h0001}, '{1,16'h1001}, '{2,16'h2001}, '{3,16'h3001},
                '{0,16'h0002}, '{1,16'h1002}, '{2,16'h2002}, '{3,16'h3002}};
    ab = acc_data.size();
    pb = pop_ch.size();
    cnt_base = o_cnt;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NUM_CH; k++) push(k, DATA_W'(k * 16'h1000 + i));
    wait_acc("rr4", ab + 12, 40);
    check_seq("rr4", ab, 12);
    check("rr4_burst", acc_cyc[ab+11] - acc_cyc[ab], 11);
    check("rr4_span", acc_cyc[ab+11] - pop_cyc[pb], 13);
    wait_idle("rr4");
    check("cnt12", o_cnt - cnt_base, STATS ? 32'd12 : 32'd0);

    // Single busy channel: back-to-back pops of channel 2.
    exp_tab[0] = '{2, 16'h2200}; exp_tab[1] = '{2, 16'h2201};
    exp_tab[2] = '{2, 16'h2202}; exp_tab[3] = '{2, 16'h2203};
    exp_tab[4] = '{2, 16'h2204};
    ab = acc_data.size();
    pb = pop_ch.size();
    for (int i = 0; i < 5; i++) push(2, DATA_W'(16'h2200 + i));
    wait_acc("solo", ab + 5, 30);
    check_seq("solo", ab, 5);
    check("solo_pops", pop_ch.size() - pb, 5);
    for (int i = 0; i < 5; i++) check($sformatf("solo_popch%0d", i), pop_ch[pb+i], 2);
    check("solo_popspan", pop_cyc[pb+4] - pop_cyc[pb], 4);
    check("solo_accspan", acc_cyc[ab+4] - acc_cyc[ab], 4);
    wait_idle("solo");

    // Backpressure: rr_ptr is 3 after the channel-2 run.
    o_ready = 1'b0;
    ab = acc_data.size();
    pb = pop_ch.size();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NUM_CH; k++) push(k, DATA_W'(k * 16'h1000 + 16'h0100 + i));
    changes = 0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) held = o_data;
      if (i > 3 && o_data !== held) changes++;
    end
    check("stall_pops", pop_ch.size() - pb, 2);
    check("stall_valid", o_valid, 1'b1);
    check("stall_changes", changes, 0);
    check("stall_head_data", o_data, 16'h3100);
    check("stall_head_ch", o_ch, 2'd3);
    exp_tab = '{'{3,16'h3100}, '{0,16'h0100}, '{1,16'h1100}, '{2,16'h2100},
                '{3,16'h3101}, '{0,16'h0101}, '{1,16'h1101}, '{2,16'h2101},
                '{3,16'h3102}, '{0,16'h0102}, '{1,16'h1102}, '{2,16'h2102}};
    o_ready = 1'b1;
    wait_acc("stall", ab + 12, 40);
    check_seq("stall", ab, 12);
    wait_idle("stall");

    // Wrap: rr_ptr=3, ch3 empty -> ch0, then rr_ptr=1 picks ch1 before ch0 again.
    exp_tab[0] = '{0, 16'h0500}; exp_tab[1] = '{1, 16'h1500}; exp_tab[2] = '{0, 16'h0501};
    ab = acc_data.size();
    push(0, 16'h0500);
    push(0, 16'h0501);
    push(1, 16'h1500);
    wait_acc("wrap", ab + 3, 20);
    check_seq("wrap", ab, 3);
    wait_idle("wrap");

    // Reset while streaming: outputs clear at once, then a fresh word comes out.
    for (int i = 0; i < 8; i++) push(0, DATA_W'(16'h0700 + i));
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_pop", ch_pop, 4'h0);
    check("midrst_data", o_data, 16'h0000);
    check("midrst_cnt", o_cnt, 32'd0);
    repeat (2) tick();
    exp_first = mem[0][rd_idx[0] % MEMD];
    ab = acc_data.size();
    pb = pop_ch.size();
    rst = 1'b0;
    wait_acc("midrst", ab + 1, 20);
    check("midrst_first", acc_data[ab], exp_first);
    check("midrst_popch", pop_ch[pb], 0);
    wait_idle("midrst");
    check("final_cnt", o_cnt, STATS ? 32'(acc_since_rst) : 32'd0);
    check("pop_rules", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
